// File: rtl/m_axi_read_split.sv
// AXI4 read master that splits one core read request into INCR bursts bounded by
// AXI_MAX_BURST_LEN and 4 KB boundaries, with at most MAX_OUTSTANDING bursts in flight.
module m_axi_read_split #(
    parameter int AXI_AWIDTH        = 64,
    parameter int AXI_DWIDTH        = 64,
    parameter int AXI_MAX_BURST_LEN = 256,
    parameter int MAX_OUTSTANDING   = 4,
    parameter int ID                = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [3:0]            m_arid,
    output logic [AXI_AWIDTH-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    input  logic [3:0]            m_rid,
    input  logic [AXI_DWIDTH-1:0] m_rdata,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic                  m_rlast,
    input  logic [1:0]            m_rresp,
    input  logic                  core_read_request_valid,
    output logic                  core_read_request_ready,
    input  logic [AXI_AWIDTH-1:0] core_read_addr,
    input  logic [31:0]           core_read_len,
    output logic [AXI_DWIDTH-1:0] core_read_data,
    output logic                  core_read_data_valid,
    input  logic                  core_read_data_ready,
    output logic                  core_read_data_last,
    output logic                  core_read_done,
    output logic                  core_read_error
);
    localparam int SZ = $clog2(AXI_DWIDTH / 8);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0]         MAX_OUT   = OW'(MAX_OUTSTANDING);
    localparam logic [AXI_AWIDTH-1:0] LOW_MASK  = AXI_AWIDTH'((AXI_DWIDTH / 8) - 1);
    localparam logic [31:0]           MAX_BURST = 32'(AXI_MAX_BURST_LEN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [AXI_AWIDTH-1:0] addr_q, addr_d;
    logic [31:0]           ar_rem_q, ar_rem_d;
    logic [31:0]           beat_rem_q, beat_rem_d;
    logic [OW-1:0]         outst_q, outst_d;
    logic [7:0]            arlen_q, arlen_d;
    logic                  sized_q, sized_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  active_s;
    logic                  ar_hs_s;
    logic                  r_hs_s;
    logic                  r_last_hs_s;
    logic [8:0]            burst_s;
    logic [AXI_AWIDTH-1:0] aligned_addr_s;
    logic [31:0]           ar_rem_next_s;

    // Burst length (minus one) limited by remaining beats, max burst and the 4 KB page.
    function automatic logic [7:0] f_arlen(input logic [AXI_AWIDTH-1:0] a, input logic [31:0] rem);
        logic [31:0] to_4k;
        logic [31:0] b;
        to_4k = (32'd4096 - {20'd0, a[11:0]}) >> SZ;
        b     = (rem < MAX_BURST) ? rem : MAX_BURST;
        b     = (b < to_4k) ? b : to_4k;
        return 8'(b - 32'd1);
    endfunction

    assign active_s       = (state_q != S_IDLE);
    assign burst_s        = {1'b0, arlen_q} + 9'd1;
    assign aligned_addr_s = core_read_addr & ~LOW_MASK;
    assign ar_rem_next_s  = ar_rem_q - {23'd0, burst_s};

    assign m_arid    = 4'(ID);
    assign m_arsize  = 3'(SZ);
    assign m_arburst = 2'b01;
    assign m_araddr  = addr_q;
    assign m_arlen   = arlen_q;
    // arvalid only once the burst has been sized, which leaves a one-cycle gap after each handshake
    assign m_arvalid = (state_q == S_ISSUE) & sized_q & (outst_q < MAX_OUT);

    assign ar_hs_s     = m_arvalid & m_arready;
    assign r_hs_s      = m_rvalid & m_rready;
    assign r_last_hs_s = r_hs_s & m_rlast;

    assign m_rready                = core_read_data_ready & active_s;
    assign core_read_data          = m_rdata;
    assign core_read_data_valid    = m_rvalid & active_s;
    assign core_read_data_last     = core_read_data_valid & (beat_rem_q == 32'd1);
    assign core_read_request_ready = (state_q == S_IDLE);
    assign core_read_done          = done_q;
    assign core_read_error         = err_q;

    // Next-state, burst sizing and beat accounting.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ar_rem_d   = ar_rem_q;
        beat_rem_d = beat_rem_q;
        arlen_d    = arlen_q;
        sized_d    = sized_q;
        err_d      = err_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (core_read_request_valid) begin
                    addr_d     = aligned_addr_s;
                    ar_rem_d   = core_read_len;
                    beat_rem_d = core_read_len;
                    err_d      = 1'b0;
                    if (core_read_len == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        arlen_d = f_arlen(aligned_addr_s, core_read_len);
                        sized_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (ar_hs_s) begin
                    addr_d   = addr_q + (AXI_AWIDTH'(burst_s) << SZ);
                    ar_rem_d = ar_rem_next_s;
                    sized_d  = 1'b0;
                    if (ar_rem_next_s == 32'd0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (!sized_q) begin
                    arlen_d = f_arlen(addr_q, ar_rem_q);
                    sized_d = 1'b1;
                end else begin
                    sized_d = sized_q;
                end
            end
            S_DRAIN: begin
                state_d = S_DRAIN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (r_hs_s) begin
            beat_rem_d = beat_rem_q - 32'd1;
            if (m_rresp[1]) begin
                err_d = 1'b1;
            end else begin
                err_d = err_d;
            end
            if (beat_rem_q == 32'd1) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                done_d = done_d;
            end
        end else begin
            beat_rem_d = beat_rem_d;
        end
    end

    // Outstanding bursts: AR handshake adds one, final R beat of a burst retires one.
    always_comb begin
        outst_d = outst_q;
        case ({ar_hs_s, r_last_hs_s})
            2'b10:   outst_d = outst_q + {{(OW-1){1'b0}}, 1'b1};
            2'b01:   outst_d = (outst_q != {OW{1'b0}}) ? outst_q - {{(OW-1){1'b0}}, 1'b1} : outst_q;
            default: outst_d = outst_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= {AXI_AWIDTH{1'b0}};
            ar_rem_q   <= 32'd0;
            beat_rem_q <= 32'd0;
            outst_q    <= {OW{1'b0}};
            arlen_q    <= 8'd0;
            sized_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ar_rem_q   <= ar_rem_d;
            beat_rem_q <= beat_rem_d;
            outst_q    <= outst_d;
            arlen_q    <= arlen_d;
            sized_q    <= sized_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_m_axi_read_split.sv
// Scoreboard bench for m_axi_read_split: random AXI slave, reference burst split model,
// monitor comparing AR requests, forwarded beats, done pulses and the sticky error.
module tb_m_axi_read_split;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int MAXB = 256;
    localparam int MAXO = 2;
    localparam logic [63:0] SALT = 64'hA5A5_5A5A_0F0F_F0F0;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    m_arid;
    logic [AW-1:0] m_araddr;
    logic          m_arvalid;
    logic          m_arready;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic [3:0]    m_rid;
    logic [DW-1:0] m_rdata;
    logic          m_rvalid;
    logic          m_rready;
    logic          m_rlast;
    logic [1:0]    m_rresp;
    logic          core_read_request_valid;
    logic          core_read_request_ready;
    logic [AW-1:0] core_read_addr;
    logic [31:0]   core_read_len;
    logic [DW-1:0] core_read_data;
    logic          core_read_data_valid;
    logic          core_read_data_ready;
    logic          core_read_data_last;
    logic          core_read_done;
    logic          core_read_error;

    always #5 clk = ~clk;

    m_axi_read_split #(
        .AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .AXI_MAX_BURST_LEN(MAXB),
        .MAX_OUTSTANDING(MAXO), .ID(2)
    ) dut (
        .clk(clk), .rst(rst),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rlast(m_rlast), .m_rresp(m_rresp),
        .core_read_request_valid(core_read_request_valid),
        .core_read_request_ready(core_read_request_ready),
        .core_read_addr(core_read_addr), .core_read_len(core_read_len),
        .core_read_data(core_read_data), .core_read_data_valid(core_read_data_valid),
        .core_read_data_ready(core_read_data_ready), .core_read_data_last(core_read_data_last),
        .core_read_done(core_read_done), .core_read_error(core_read_error)
    );

    typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [63:0] data; logic last; } beat_t;

    ar_t   exp_ar_q[$];
    beat_t exp_beat_q[$];
    ar_t   slv_q[$];
    int    checks = 0;
    int    errors = 0;
    int    slv_idx = 0;
    int    slv_beat = 0;
    int    err_beat = -1;
    int    beat_k = 0;
    int    outst = 0;
    int    ar_total = 0;
    int    done_cnt = 0;
    bit    exp_err = 1'b0;
    bit    r_hold = 1'b0;
    bit    r_stall = 1'b0;
    bit    rand_ready = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Reference model: split into bursts of min(remaining, MAXB, beats left in the 4 KB page).
    task automatic push_req(input logic [63:0] addr, input int unsigned len);
        logic [63:0] a;
        int unsigned rem, k, b, to4k;
        ar_t   ar;
        beat_t bt;
        a   = addr & ~64'h7;
        rem = len;
        k   = 0;
        while (rem > 0) begin
            to4k = 32'((64'd4096 - (a % 64'd4096)) / 64'd8);
            b = rem;
            if (b > MAXB) b = MAXB;
            if (b > to4k) b = to4k;
            ar.addr = a;
            ar.len  = 8'(b - 1);
            exp_ar_q.push_back(ar);
            for (int i = 0; i < int'(b); i++) begin
                bt.data = (a + 64'(i) * 64'd8) ^ SALT;
                bt.last = ((k + i) == (len - 1));
                exp_beat_q.push_back(bt);
            end
            a   = a + 64'(b) * 64'd8;
            rem = rem - b;
            k   = k + b;
        end
    endtask

    // Slave and core-side driver: inputs change 1 time unit after the rising edge.
    initial begin : slave
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0;
        m_rresp = 2'b00; m_rid = 4'd0; core_read_data_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_arready = ($urandom_range(0, 9) < 6);
            core_read_data_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (slv_q.size() > 0 && !r_hold && (r_stall || $urandom_range(0, 9) < 7)) begin
                m_rvalid = 1'b1;
                m_rdata  = (slv_q[0].addr + 64'(slv_idx) * 64'd8) ^ SALT;
                m_rlast  = (slv_idx == int'(slv_q[0].len));
                m_rresp  = (slv_beat == err_beat) ? 2'b10 : 2'b00;
            end else begin
                m_rvalid = 1'b0;
                m_rlast  = 1'b0;
                m_rresp  = 2'b00;
            end
        end
    end

    // Monitor: samples on the falling edge the handshakes that complete at the next rising edge.
    initial begin : monitor
        ar_t a;
        beat_t b;
        bit done_exp, prev_ar_hs, prev_stall;
        logic [63:0] prev_addr;
        logic [7:0]  prev_len;
        done_exp = 1'b0; prev_ar_hs = 1'b0; prev_stall = 1'b0; prev_addr = '0; prev_len = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_ar_q.delete(); exp_beat_q.delete(); slv_q.delete();
                slv_idx = 0; slv_beat = 0; outst = 0; r_stall = 1'b0; exp_err = 1'b0; beat_k = 0;
                done_exp = 1'b0; prev_ar_hs = 1'b0; prev_stall = 1'b0;
            end else begin
                chk("done_pulse", core_read_done, done_exp);
                if (core_read_done) done_cnt++;
                done_exp = 1'b0;
                if (prev_ar_hs) chk("arvalid_gap", m_arvalid, 0);
                if (prev_stall) begin
                    chk("araddr_stable", m_araddr, prev_addr);
                    chk("arlen_stable", m_arlen, prev_len);
                end
                if (core_read_request_valid && core_read_request_ready) begin
                    exp_err = 1'b0; beat_k = 0; slv_beat = 0;
                    if (core_read_len == 32'd0) done_exp = 1'b1;
                end
                if (!core_read_request_ready) chk("rready_mirror", m_rready, core_read_data_ready);
                else chk("rready_idle", m_rready, 0);
                if (m_arvalid && m_arready) begin
                    chk("outstanding_limit", outst < MAXO, 1);
                    if (exp_ar_q.size() == 0) begin
                        chk("ar_unexpected", 1, 0);
                    end else begin
                        a = exp_ar_q.pop_front();
                        chk("araddr", m_araddr, a.addr);
                        chk("arlen", m_arlen, a.len);
                    end
                    a.addr = m_araddr;
                    a.len  = m_arlen;
                    slv_q.push_back(a);
                    outst++;
                    ar_total++;
                end
                if (m_rvalid && m_rready) begin
                    if (m_rlast) begin
                        if (slv_q.size() > 0) void'(slv_q.pop_front());
                        slv_idx = 0;
                        outst--;
                    end else begin
                        slv_idx++;
                    end
                    slv_beat++;
                end
                if (core_read_data_valid && core_read_data_ready) begin
                    if (exp_beat_q.size() == 0) begin
                        chk("beat_unexpected", 1, 0);
                    end else begin
                        b = exp_beat_q.pop_front();
                        chk("rdata", core_read_data, b.data);
                        chk("data_last", core_read_data_last, b.last);
                        chk("error_sticky", core_read_error, exp_err);
                        if (b.last) done_exp = 1'b1;
                    end
                    if (beat_k == err_beat) exp_err = 1'b1;
                    beat_k++;
                end
                r_stall    = m_rvalid && !m_rready;
                prev_ar_hs = m_arvalid && m_arready;
                prev_stall = m_arvalid && !m_arready;
                prev_addr  = m_araddr;
                prev_len   = m_arlen;
            end
        end
    end

    task automatic do_req(input logic [63:0] addr, input int unsigned len);
        int n;
        n = 0;
        while (!core_read_request_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready", core_read_request_ready, 1);
        push_req(addr, len);
        core_read_request_valid = 1'b1;
        core_read_addr = addr;
        core_read_len  = len;
        @(posedge clk); #1;
        core_read_request_valid = 1'b0;
        chk("err_clear_on_accept", core_read_error, 0);
        chk("arvalid_first", m_arvalid, len != 0);
    endtask

    task automatic finish_req(input int unsigned len, input int done_before);
        int n;
        n = 0;
        while (!(core_read_request_ready && exp_ar_q.size() == 0 && exp_beat_q.size() == 0)
               && n < int'(60 * len + 300)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_complete", (exp_ar_q.size() == 0 && exp_beat_q.size() == 0), 1);
        repeat (2) begin @(posedge clk); #1; end
        chk("done_count", done_cnt, done_before + 1);
        chk("error_final", core_read_error, (err_beat >= 0 && err_beat < int'(len)));
    endtask

    initial begin : driver
        int db, at, n;
        logic [63:0] ad;
        int unsigned ln;
        rst = 1'b1;
        core_read_request_valid = 1'b0;
        core_read_addr = '0;
        core_read_len  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_araddr", m_araddr, 0);
        chk("rst_arlen", m_arlen, 0);
        chk("rst_req_ready", core_read_request_ready, 1);
        chk("rst_data_valid", core_read_data_valid, 0);
        chk("rst_data_last", core_read_data_last, 0);
        chk("rst_done", core_read_done, 0);
        chk("rst_error", core_read_error, 0);
        chk("rst_rready", m_rready, 0);
        chk("arid", m_arid, 2);
        chk("arsize", m_arsize, 3);
        chk("arburst", m_arburst, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        db = done_cnt; at = ar_total;
        do_req(64'h0, 4); finish_req(4, db);
        chk("ar_count_len4", ar_total - at, 1);

        db = done_cnt; at = ar_total;
        do_req(64'h0FF0, 600); finish_req(600, db);
        chk("ar_count_len600", ar_total - at, 4);

        r_hold = 1'b1;
        db = done_cnt; at = ar_total;
        do_req(64'h0, 1024);
        repeat (40) begin @(posedge clk); #1; end
        chk("ar_count_hold", ar_total - at, 2);
        chk("arvalid_hold", m_arvalid, 0);
        r_hold = 1'b0;
        finish_req(1024, db);

        err_beat = 2;
        db = done_cnt;
        do_req(64'h2000, 8); finish_req(8, db);
        err_beat = -1;
        db = done_cnt;
        do_req(64'h3008, 3); finish_req(3, db);

        rand_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            ad = {32'h0, $urandom};
            ln = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 700);
            err_beat = ($urandom_range(0, 1) == 1 && ln > 0) ? int'($urandom_range(0, ln - 1)) : -1;
            db = done_cnt;
            do_req(ad, ln);
            finish_req(ln, db);
        end
        err_beat = -1;

        db = done_cnt;
        do_req(64'h0FF0, 600);
        n = 0;
        while (exp_ar_q.size() != 0 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin @(posedge clk); #1; end
        chk("drain_reached", (exp_ar_q.size() == 0 && exp_beat_q.size() > 0), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req_ready", core_read_request_ready, 1);
        chk("midrst_arvalid", m_arvalid, 0);
        chk("midrst_rready", m_rready, 0);
        chk("midrst_done", core_read_done, 0);
        rst = 1'b0;
        chk("midrst_no_done", done_cnt, db);

        db = done_cnt; at = ar_total;
        do_req(64'h0, 4); finish_req(4, db);
        chk("ar_count_after_rst", ar_total - at, 1);
        db = done_cnt; at = ar_total;
        do_req(64'h40, 0); finish_req(0, db);
        chk("ar_count_len0", ar_total - at, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
